// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_capture: per-channel PWM high-time measurement over hsync frames,      |
// | with a snapshot buffer drained one word per channel over valid/ready.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_capture #(
    parameter int DWIDTH = 8,
    parameter int STAGE  = 8,
    localparam int CHW   = (STAGE > 1) ? $clog2(STAGE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hsync,
    input  logic [STAGE-1:0]  pwm_in,
    input  logic              ready,
    output logic              valid,
    output logic [DWIDTH-1:0] data,
    output logic [CHW-1:0]    ch,
    output logic              overrun
);

    localparam logic [DWIDTH-1:0] C_MAX  = '1;
    localparam logic [CHW-1:0]    C_LAST = CHW'(STAGE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_frame_end;
    logic              w_load;

    logic [DWIDTH-1:0] r_cnt  [STAGE];
    logic [DWIDTH-1:0] r_snap [STAGE];
    logic              r_valid;
    logic [CHW-1:0]    r_ch;
    logic              r_ovr;

    logic              w_xfer;
    logic              w_last_xfer;
    logic              w_accept;
    logic              w_drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        w_load      = 1'b0;
        if (!start) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARM;
                S_ARM: begin
                    if (hsync) begin
                        w_state_nxt = S_RUN;
                        w_load      = 1'b1;
                    end
                end
                S_RUN: begin
                    if (hsync) begin
                        w_frame_end = 1'b1;
                        w_load      = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A frame end may reuse the buffer only if it is empty or its last word leaves this cycle.
    assign w_xfer      = r_valid && ready;
    assign w_last_xfer = w_xfer && (r_ch == C_LAST);
    assign w_accept    = w_frame_end && (!r_valid || w_last_xfer);
    assign w_drop      = w_frame_end && !w_accept;

    always_ff @(posedge clk) begin
        if (!rst || !start) begin
            for (int i = 0; i < STAGE; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGE; i++) begin
                if (w_load) begin
                    r_cnt[i] <= DWIDTH'(pwm_in[i]);
                end else if ((r_state == S_RUN) && pwm_in[i] && (r_cnt[i] != C_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + DWIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGE; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < STAGE; i++) begin
                r_snap[i] <= r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || !start) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ch    <= '0;
        end else if (w_xfer) begin
            if (r_ch == C_LAST) begin
                r_valid <= 1'b0;
                r_ch    <= '0;
            end else begin
                r_ch    <= r_ch + CHW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovr <= 1'b0;
        end else begin
            r_ovr <= w_drop;
        end
    end

    assign valid   = r_valid;
    assign ch      = r_ch;
    assign data    = r_valid ? r_snap[r_ch] : '0;
    assign overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_capture: randomized frames against a frame-level reference model;   |
// | expected words and overrun pulses are queued and consumed by a monitor.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pwm_capture;

    localparam int DW = 8;
    localparam int ST = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hsync;
    logic [ST-1:0] pwm_in;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] ch;
    logic          overrun;

    always #5 clk = ~clk;

    pwm_capture #(.DWIDTH(DW), .STAGE(ST)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hsync   (hsync),
        .pwm_in  (pwm_in),
        .ready   (ready),
        .valid   (valid),
        .data    (data),
        .ch      (ch),
        .overrun (overrun)
    );

    typedef struct {
        int ch;
        int data;
    } word_t;

    word_t exp_q[$];
    int    ovr_q[$];
    int    log_q[$];
    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    bit    armed     = 1'b0;
    bit    running   = 1'b0;
    bit    zero_data = 1'b0;
    bit    mon_en    = 1'b0;
    bit    m_ev;
    bit    m_eo;
    int    sums[ST];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Frame-level model: accumulate high cycles per frame; a frame end either
    // hands a full set of words to the scoreboard or, if words are still owed, is dropped.
    always @(posedge clk) begin
        cyc++;
        if (!rst || !start) begin
            if (!rst) zero_data = 1'b1;
            armed   = 1'b0;
            running = 1'b0;
            exp_q.delete();
            for (int i = 0; i < ST; i++) sums[i] = 0;
        end else if (running) begin
            if (hsync) begin
                if (exp_q.size() > 0) begin
                    ovr_q.push_back(cyc);
                end else begin
                    for (int i = 0; i < ST; i++) exp_q.push_back('{ch: i, data: sat(sums[i])});
                    zero_data = 1'b0;
                end
                for (int i = 0; i < ST; i++) sums[i] = int'(pwm_in[i]);
            end else begin
                for (int i = 0; i < ST; i++) sums[i] += int'(pwm_in[i]);
            end
        end else if (armed) begin
            if (hsync) begin
                running = 1'b1;
                for (int i = 0; i < ST; i++) sums[i] = int'(pwm_in[i]);
            end
        end else begin
            armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            m_ev = (exp_q.size() > 0);
            m_eo = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
            check("valid", 32'(valid), 32'(m_ev));
            if (m_ev) begin
                check("ch", 32'(ch), exp_q[0].ch);
                check("data", 32'(data), exp_q[0].data);
            end else begin
                check("idle_ch", 32'(ch), 0);
                if (zero_data) check("reset_data", 32'(data), 0);
            end
            check("overrun", 32'(overrun), 32'(m_eo));
            if (m_eo) void'(ovr_q.pop_front());
            if (m_ev && ready) begin
                log_q.push_back(int'(data));
                void'(exp_q.pop_front());
            end
        end
    end

    // hN < 0 selects random PWM for that channel; rmode: 0 ready=1, 1 random,
    // 2 stalled for the first six cycles, 3 stalled all frame.
    task automatic run_frame(input int len, input int h0, input int h1, input int h2, input int h3,
                             input int rmode, input int abort_at, input int abort_kind);
        int            hi[ST];
        logic [ST-1:0] p;
        logic          r;
        hi = '{h0, h1, h2, h3};
        for (int j = 0; j < len; j++) begin
            for (int i = 0; i < ST; i++) begin
                p[i] = (hi[i] < 0) ? 1'($urandom_range(0, 1)) : (j < hi[i]);
            end
            case (rmode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                2:       r = (j > 5);
                default: r = 1'b0;
            endcase
            @(posedge clk);
            #1;
            hsync  = (j == 0);
            pwm_in = p;
            ready  = r;
            rst    = !((j == abort_at) && (abort_kind == 0));
            start  = !((j == abort_at) && (abort_kind == 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int basic[ST];
        basic  = '{25, 0, 100, 60};
        rst    = 1'b0;
        start  = 1'b0;
        hsync  = 1'b0;
        ready  = 1'b0;
        pwm_in = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        ready  = 1'b1;
        start  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;

        // Basic capture, then first saturated frame flushes the third basic frame.
        log_q.delete();
        repeat (3) run_frame(100, 25, 0, 100, 60, 0, -1, 0);
        run_frame(300, 300, 300, 300, 300, 0, -1, 0);
        check("basic_count", log_q.size(), 3 * ST);
        for (int k = 0; k < log_q.size() && k < 3 * ST; k++) begin
            check("basic_word", log_q[k], basic[k % ST]);
        end

        // Saturation, carried out through a backpressured drain.
        log_q.delete();
        run_frame(300, 300, 300, 300, 300, 0, -1, 0);
        run_frame(50, 10, 20, 30, 40, 2, -1, 0);
        check("sat_count", log_q.size(), 2 * ST);
        for (int k = 0; k < log_q.size() && k < 2 * ST; k++) begin
            check("sat_word", log_q[k], 255);
        end

        // Overrun: drain stalled across the next frame end.
        run_frame(10, -1, -1, -1, -1, 3, -1, 0);
        run_frame(10, -1, -1, -1, -1, 2, -1, 0);
        run_frame(10, -1, -1, -1, -1, 0, -1, 0);

        // Frame end coinciding with the final transfer.
        repeat (4) run_frame(4, 1, 2, 3, 4, 0, -1, 0);

        // Reset and start abort while ch==2 is presented.
        run_frame(20, -1, -1, -1, -1, 0, -1, 0);
        run_frame(20, -1, -1, -1, -1, 0, 3, 0);
        repeat (2) run_frame(20, -1, -1, -1, -1, 0, -1, 0);
        run_frame(20, -1, -1, -1, -1, 0, 3, 1);
        repeat (2) run_frame(20, -1, -1, -1, -1, 0, -1, 0);

        // Randomized frames, including frames too short to drain.
        repeat (40) run_frame($urandom_range(3, 24), -1, -1, -1, -1, $urandom_range(0, 1), -1, 0);

        repeat (12) begin
            @(posedge clk);
            #1;
            hsync = 1'b0;
            ready = 1'b1;
        end
        @(negedge clk);
        #1;
        check("words_outstanding", exp_q.size(), 0);
        check("overrun_outstanding", ovr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
